// File: rtl/seq_mult_unit_if.sv
// seq_mult_unit_if -- operator-side bus of the sequential signed multiplier.
//   Run          start request (level-sampled)
//   ClearA_LoadB load request (level-sampled)
//   S            switch value: multiplicand, or multiplier when loading
//   Aval / Bval  product high / low half
//   X            sign-extension bit (product sign when Done)
//   Busy / Done  status decoded from the controller state
// The master modport drives the requests, and the slave modport (the
// multiplier) drives the results.
interface seq_mult_unit_if #(
   parameter int WIDTH = 8
);
   logic             Run;
   logic             ClearA_LoadB;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] Aval;
   logic [WIDTH-1:0] Bval;
   logic             X;
   logic             Busy;
   logic             Done;

   modport master (
      output Run, ClearA_LoadB, S,
      input  Aval, Bval, X, Busy, Done
   );

   modport slave (
      input  Run, ClearA_LoadB, S,
      output Aval, Bval, X, Busy, Done
   );
endinterface

// File: rtl/seq_mult_unit.sv
// seq_mult_unit -- parametrised signed shift-add multiplier.
// The controller steps IDLE -> CLR -> (ADD -> SHIFT) x WIDTH -> DONE.
// A bit counter tracks the steps instead of one state per bit. The
// datapath is X:A:B, and the product ends up in {A,B}.
//   Clk    rising-edge clock
//   Reset  synchronous, active-high; returns to IDLE with X, A, B and the counter cleared
//   bus    seq_mult_unit_if.slave (Run, ClearA_LoadB, S in; Aval, Bval, X, Busy, Done out)
// Every output comes from a register or from the state register alone.
module seq_mult_unit #(
   parameter int WIDTH = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   seq_mult_unit_if.slave bus
);

   localparam int              CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      ADD,
      SHIFT,
      DONE
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic signed [WIDTH-1:0] a_q;
   logic signed [WIDTH-1:0] b_q;
   logic                    x_q;
   logic [CNT_W-1:0]        cnt_q;

   // Sign-extended add/subtract one bit wider than the operands, so the
   // carry-out lands in X. The MSB of the multiplier has negative weight,
   // so its partial product is subtracted.
   function automatic logic signed [WIDTH:0] add_sub(
      input logic signed [WIDTH-1:0] acc,
      input logic signed [WIDTH-1:0] m,
      input logic                    sub
   );
      logic signed [WIDTH:0] acc_x;
      logic signed [WIDTH:0] m_x;
      acc_x = acc;
      m_x   = m;
      return sub ? (acc_x - m_x) : (acc_x + m_x);
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Load has priority over Run in IDLE. DONE waits for Run to drop, so a
   // held Run cannot start a second multiply.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!bus.ClearA_LoadB && bus.Run) state_nxt = CLR;
         CLR:     state_nxt = ADD;
         ADD:     state_nxt = SHIFT;
         SHIFT:   state_nxt = (cnt_q == LAST_BIT) ? DONE : ADD;
         DONE:    if (!bus.Run) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         a_q   <= '0;
         b_q   <= '0;
         x_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ClearA_LoadB) begin
                  a_q <= '0;
                  x_q <= 1'b0;
                  b_q <= $signed(bus.S);
               end
            end
            // B is kept, so a Run with no reload multiplies the previous low half.
            CLR: begin
               a_q   <= '0;
               x_q   <= 1'b0;
               cnt_q <= '0;
            end
            ADD: begin
               if (b_q[0]) {x_q, a_q} <= add_sub(a_q, $signed(bus.S), cnt_q == LAST_BIT);
               else        x_q        <= a_q[WIDTH-1];
            end
            // Arithmetic right shift of X:A:B. X is copied into A's MSB and keeps its own value.
            SHIFT: begin
               a_q   <= {x_q, a_q[WIDTH-1:1]};
               b_q   <= {a_q[0], b_q[WIDTH-1:1]};
               cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.Aval = a_q;
   assign bus.Bval = b_q;
   assign bus.X    = x_q;
   assign bus.Busy = (state == CLR) || (state == ADD) || (state == SHIFT);
   assign bus.Done = (state == DONE);

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit -- self-checking bench for seq_mult_unit.
// It instantiates WIDTH=8 and WIDTH=4 copies of the multiplier. Results are
// compared against a signed-arithmetic reference.
module tb_seq_mult_unit;

   logic Clk = 1'b0;
   logic rst8;
   logic rst4;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 Clk = ~Clk;

   seq_mult_unit_if #(.WIDTH(8)) b8 ();
   seq_mult_unit_if #(.WIDTH(4)) b4 ();

   seq_mult_unit #(.WIDTH(8)) dut8 (.Clk(Clk), .Reset(rst8), .bus(b8.slave));
   seq_mult_unit #(.WIDTH(4)) dut4 (.Clk(Clk), .Reset(rst4), .bus(b4.slave));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] mul8(input logic [7:0] b, input logic [7:0] s);
      logic signed [15:0] p;
      p = 16'($signed(b)) * 16'($signed(s));
      return p;
   endfunction

   function automatic logic [7:0] mul4(input logic [3:0] b, input logic [3:0] s);
      logic signed [7:0] p;
      p = 8'($signed(b)) * 8'($signed(s));
      return p;
   endfunction

   task automatic edge1();
      @(posedge Clk);
      #1;
   endtask

   task automatic load8(input logic [7:0] v);
      b8.S = v;
      b8.ClearA_LoadB = 1'b1;
      edge1();
      b8.ClearA_LoadB = 1'b0;
   endtask

   // Starts a multiply and returns the number of edges until Done is seen.
   task automatic run8(input logic [7:0] s, input bit hold, output int lat);
      b8.S   = s;
      b8.Run = 1'b1;
      edge1();
      chk("busy_after_start8", 32'(b8.Busy), 1);
      if (!hold) b8.Run = 1'b0;
      lat = 0;
      while (!b8.Done && lat < 60) begin
         edge1();
         lat++;
      end
   endtask

   task automatic release8();
      b8.Run = 1'b0;
      edge1();
      chk("idle_after_done8", 32'({b8.Busy, b8.Done}), 0);
   endtask

   task automatic load4(input logic [3:0] v);
      b4.S = v;
      b4.ClearA_LoadB = 1'b1;
      edge1();
      b4.ClearA_LoadB = 1'b0;
   endtask

   task automatic run4(input logic [3:0] s, output int lat);
      b4.S   = s;
      b4.Run = 1'b1;
      edge1();
      b4.Run = 1'b0;
      lat = 0;
      while (!b4.Done && lat < 40) begin
         edge1();
         lat++;
      end
      if (lat >= 40) chk("timeout4", 32'(lat), 9);
   endtask

   initial begin
      int          lat;
      logic [7:0]  rb;
      logic [7:0]  rs;
      logic [15:0] p;
      logic [7:0]  p4;

      b8.Run = 1'b0; b8.ClearA_LoadB = 1'b0; b8.S = '0;
      b4.Run = 1'b0; b4.ClearA_LoadB = 1'b0; b4.S = '0;
      rst8 = 1'b1;
      rst4 = 1'b1;
      edge1();
      edge1();
      chk("rst_A", 32'(b8.Aval), 0);
      chk("rst_B", 32'(b8.Bval), 0);
      chk("rst_X", 32'(b8.X), 0);
      chk("rst_busy_done", 32'({b8.Busy, b8.Done}), 0);
      chk("rst4_all", 32'({b4.X, b4.Aval, b4.Bval, b4.Busy, b4.Done}), 0);
      rst8 = 1'b0;
      rst4 = 1'b0;

      // 59 * 7 = 413; Done must hold while Run stays high.
      load8(8'h3B);
      run8(8'h07, 1'b1, lat);
      chk("lat_t1", 32'(lat), 17);
      chk("prod_t1", 32'({b8.Aval, b8.Bval}), 32'h019D);
      chk("x_t1", 32'(b8.X), 0);
      repeat (3) begin
         edge1();
         chk("done_hold_t1", 32'({b8.Busy, b8.Done}), 1);
      end
      release8();

      load8(8'hF9);
      run8(8'h3B, 1'b0, lat);
      chk("prod_t2a", 32'({b8.Aval, b8.Bval}), 32'hFE63);
      chk("x_t2a", 32'(b8.X), 1);
      release8();
      load8(8'h80);
      run8(8'h80, 1'b0, lat);
      chk("prod_t2b", 32'({b8.Aval, b8.Bval}), 32'h4000);
      chk("x_t2b", 32'(b8.X), 0);
      release8();

      // Run again without a reload: B is now 0x00. Holding Run must not retrigger.
      run8(8'h80, 1'b1, lat);
      chk("prod_t3", 32'({b8.Aval, b8.Bval, b8.X}), 0);
      repeat (6) begin
         edge1();
         chk("no_retrigger_t3", 32'({b8.Busy, b8.Done}), 1);
      end
      release8();

      // Load beats Run in IDLE.
      b8.S = 8'h05; b8.Run = 1'b1; b8.ClearA_LoadB = 1'b1;
      edge1();
      b8.Run = 1'b0; b8.ClearA_LoadB = 1'b0;
      chk("load_prio_B", 32'(b8.Bval), 32'h05);
      chk("load_prio_A", 32'(b8.Aval), 0);
      chk("load_prio_status", 32'({b8.Busy, b8.Done}), 0);
      edge1();
      chk("load_prio_idle", 32'(b8.Busy), 0);
      // A load request mid-operation is ignored: 5 * 3 = 15.
      b8.S = 8'h03; b8.Run = 1'b1;
      edge1();
      b8.Run = 1'b0;
      repeat (3) edge1();
      b8.ClearA_LoadB = 1'b1;
      repeat (2) edge1();
      b8.ClearA_LoadB = 1'b0;
      lat = 0;
      while (!b8.Done && lat < 60) begin
         edge1();
         lat++;
      end
      chk("midop_load_ignored", 32'({b8.Aval, b8.Bval}), 32'h000F);
      release8();

      // Reset during cycle 6 of a multiply.
      load8(8'h11);
      b8.S = 8'h22; b8.Run = 1'b1;
      edge1();
      b8.Run = 1'b0;
      repeat (5) edge1();
      rst8 = 1'b1;
      edge1();
      rst8 = 1'b0;
      chk("midrst_regs", 32'({b8.X, b8.Aval, b8.Bval}), 0);
      chk("midrst_status", 32'({b8.Busy, b8.Done}), 0);
      edge1();
      chk("midrst_idle", 32'(b8.Busy), 0);
      load8(8'h02);
      run8(8'h03, 1'b0, lat);
      chk("after_rst_prod", 32'({b8.Aval, b8.Bval}), 32'h0006);
      release8();

      // Random operands, each followed by a back-to-back Run on the previous low half.
      repeat (25) begin
         rb = 8'($urandom);
         rs = 8'($urandom);
         load8(rb);
         run8(rs, 1'b0, lat);
         p = mul8(rb, rs);
         chk("rand_lat", 32'(lat), 17);
         chk("rand_prod", 32'({b8.Aval, b8.Bval}), 32'(p));
         chk("rand_x", 32'(b8.X), 32'(p[15]));
         release8();
         rs = 8'($urandom);
         run8(rs, 1'b0, lat);
         p = mul8(p[7:0], rs);
         chk("b2b_prod", 32'({b8.X, b8.Aval, b8.Bval}), 32'({p[15], p}));
         release8();
      end

      // WIDTH=4: -3 * 3 = -9.
      load4(4'hD);
      run4(4'h3, lat);
      chk("w4_lat", 32'(lat), 9);
      chk("w4_prod", 32'({b4.X, b4.Aval, b4.Bval}), 32'h1F7);
      edge1();
      for (int ib = 0; ib < 16; ib++) begin
         for (int is = 0; is < 16; is++) begin
            load4(4'(ib));
            run4(4'(is), lat);
            p4 = mul4(4'(ib), 4'(is));
            chk("w4_sweep", 32'({b4.X, b4.Aval, b4.Bval}), 32'({p4[7], p4}));
            edge1();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Parametrised signed shift-add multiplier: controller plus datapath (X, A, B registers).
- Successor to the fixed 8-bit multiplier control. Replaces the enumerated one-state-per-bit sequencer with a bit counter.
- Adds explicit add and shift phases, Busy/Done status, and a defined load/run priority.
- Sits between board switches/buttons (already debounced and synchronised upstream) and the hex display drivers.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32). Product is 2*WIDTH bits in A:B.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  start request, level-sampled.
- ClearA_LoadB  in  1  load request, level-sampled.
- S  in  WIDTH  switches: multiplicand, and the multiplier value when loading.
- Aval  out  WIDTH  A register (product high half).
- Bval  out  WIDTH  B register (product low half).
- X  out  1  sign-extension bit.
- Busy  out  1  high in CLR, ADD and SHIFT states.
- Done  out  1  high in DONE state.

Behaviour:
- Reset: state=IDLE; A, B, X, bit counter all 0; Busy=0, Done=0. Reset mid-operation aborts at the next edge with the same result. No partial product is retained.
- States: IDLE, CLR, ADD, SHIFT, DONE. Counter width is $clog2(WIDTH+1).
- IDLE:
  - ClearA_LoadB=1: A<=0, X<=0, B<=S; stay in IDLE.
  - Otherwise, Run=1: go to CLR.
  - If both are high, load wins and Run is ignored that cycle.
- CLR: A<=0, X<=0, counter<=0; B is kept (loaded multiplier or previous low half); go to ADD.
- ADD, when B[0]=1:
  - counter<WIDTH-1: {X,A} <= sext(A) + sext(S), computed WIDTH+1 bits wide.
  - counter==WIDTH-1: {X,A} <= sext(A) - sext(S), two's-complement subtract for the sign bit.
- ADD, when B[0]=0: A unchanged, X <= A[WIDTH-1].
- ADD always goes to SHIFT.
- SHIFT:
  - {X,A,B} <= arithmetic right shift by 1 of the (2*WIDTH+1)-bit value; X is retained as its own MSB.
  - counter<=counter+1.
  - Go to DONE if counter==WIDTH-1 before the increment; otherwise go to ADD.
- DONE: registers hold; stay in DONE while Run=1; go to IDLE when Run=0. Holding Run never retriggers a multiply.
- Latency: Done goes high 2*WIDTH+1 edges after the edge that samples Run=1 in IDLE (17 cycles for WIDTH=8).
- Input sampling:
  - Run and ClearA_LoadB are ignored in CLR, ADD and SHIFT.
  - S may change mid-operation; ADD uses its current value.
- Result: signed product of the loaded B and S, 2*WIDTH bits in {A,B}. X equals the product sign.
- Back-to-back Run without reload multiplies the previous low half (B) by S.
- All outputs are registered, or decoded from the state register only. No combinational path from inputs to outputs.

Test Plan:
1. WIDTH=8, load S=0x3B, then S=0x07 and Run pulse. Expect Busy for 17 cycles, then Done=1, A=0x01, B=0x9D, X=0 (413). Done stays high until Run drops, then IDLE.
2. WIDTH=8, load 0xF9 (-7), S=0x3B, Run. Expect A=0xFE, B=0x63, X=1 (-413). Repeat with load 0x80 and S=0x80: expect A=0x40, B=0x00, X=0 (+16384, last-step subtract check).
3. After case 2 completes, release Run, press Run again with S=0x80 and no reload. Expect A=0x00, B=0x00, X=0. Also hold Run high throughout DONE: no second operation may start.
4. WIDTH=8, Run and ClearA_LoadB high together in IDLE with S=0x05. Expect B=0x05, A=0, state IDLE, Busy=0. Then assert ClearA_LoadB mid-operation: expect no effect on B.
5. Assert Reset at cycle 6 of a multiply. Next edge: A=B=X=0, Busy=Done=0, IDLE. A subsequent load and Run of 0x02 by 0x03 gives B=0x06, A=0x00.
6. WIDTH=4, load 0xD (-3), S=0x3, Run. Expect Done after 9 cycles, A=0xF, B=0x7, X=1 (-9). Also sweep all 256 operand pairs against a reference model.
